// File: rtl/matrix_vector_seq_mac_if.sv
// ---------------------------------------------------------------------------
// matrix_vector_seq_mac_if
// Bundles the request/response signals of matrix_vector_seq_mac.
//   start      : request a multiply (sampled by the engine only when idle)
//   transpose  : 1 = use transpose(m1), sampled together with start
//   m1         : packed N x N matrix, element (row, col) at bits
//                [(row*N+col)*WIDTH +: WIDTH]
//   v1         : packed vector, element i at bits [i*WIDTH +: WIDTH]
//   v_out      : registered result vector, same packing as v1
//   busy       : operation in progress
//   done       : one-cycle pulse, v_out/overflow just updated
//   overflow   : some element of the current result was clamped or wrapped
// master = requester, slave = engine.
// ---------------------------------------------------------------------------
interface matrix_vector_seq_mac_if #(
    parameter int N     = 4,
    parameter int WIDTH = 32
);
    logic                     start;
    logic                     transpose;
    logic [N*N*WIDTH-1:0]     m1;
    logic [N*WIDTH-1:0]       v1;
    logic [N*WIDTH-1:0]       v_out;
    logic                     busy;
    logic                     done;
    logic                     overflow;

    modport master (
        output start, transpose, m1, v1,
        input  v_out, busy, done, overflow
    );

    modport slave (
        input  start, transpose, m1, v1,
        output v_out, busy, done, overflow
    );
endinterface

// File: rtl/matrix_vector_seq_mac.sv
// ---------------------------------------------------------------------------
// matrix_vector_seq_mac
// Sequential fixed-point matrix x vector multiplier. One column of the matrix
// is consumed per cycle; all N row accumulators work in parallel, so a result
// takes N accumulate cycles plus one output cycle.
//   clk_in : clock, all state changes on the rising edge
//   rst_in : asynchronous, active-high reset
//   bus    : matrix_vector_seq_mac_if.slave (start/transpose/m1/v1 in,
//            v_out/busy/done/overflow out)
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for start; operands are latched on the accepting edge
//   ACCUM  | adds column col_q products into every row accumulator
//   OUTPUT | scales, saturates/wraps, publishes v_out and pulses done
// ---------------------------------------------------------------------------
module matrix_vector_seq_mac #(
    parameter int N         = 4,
    parameter int WIDTH     = 32,
    parameter int FRAC_BITS = 16,
    parameter int SATURATE  = 1
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    matrix_vector_seq_mac_if.slave   bus
);

    localparam int CW = $clog2(N);
    localparam int PW = 2 * WIDTH;
    localparam int AW = PW + CW;

    // Result range expressed at accumulator width for the range compare.
    localparam logic signed [AW-1:0]    SAT_MAX = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0]    SAT_MIN = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] RES_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] RES_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]           col_q;
    logic                    trans_q;
    logic signed [WIDTH-1:0] m_q [N][N];
    logic signed [WIDTH-1:0] v_q [N];
    logic                    busy_q;
    logic                    done_q;
    logic                    ovf_q;
    logic [N-1:0]            res_ovf;

    logic load;
    logic accum;
    logic emit;

    // ---------------- FSM ----------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        accum   = 1'b0;
        emit    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                accum = 1'b1;
                if (col_q == CW'(N - 1)) begin
                    state_d = OUTPUT;
                end
            end
            OUTPUT: begin
                emit    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- operand capture and control registers ----------------
    // Operands are copied on the accepting edge so the requester may change
    // m1/v1/transpose freely while the operation runs.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            col_q   <= '0;
            trans_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            for (int r = 0; r < N; r++) begin
                v_q[r] <= '0;
                for (int c = 0; c < N; c++) begin
                    m_q[r][c] <= '0;
                end
            end
        end else begin
            done_q <= 1'b0;
            if (load) begin
                col_q   <= '0;
                trans_q <= bus.transpose;
                busy_q  <= 1'b1;
                for (int r = 0; r < N; r++) begin
                    v_q[r] <= bus.v1[r*WIDTH +: WIDTH];
                    for (int c = 0; c < N; c++) begin
                        m_q[r][c] <= bus.m1[(r*N+c)*WIDTH +: WIDTH];
                    end
                end
            end
            if (accum) begin
                col_q <= col_q + CW'(1);
            end
            if (emit) begin
                done_q <= 1'b1;
                busy_q <= 1'b0;
                ovf_q  <= |res_ovf;
            end
        end
    end

    // ---------------- per-row datapath ----------------
    for (genvar r = 0; r < N; r++) begin : g_row
        logic signed [WIDTH-1:0] m_sel;
        logic signed [PW-1:0]    prod;
        logic signed [AW-1:0]    acc;
        logic signed [AW-1:0]    shifted;
        logic signed [WIDTH-1:0] res;
        logic signed [WIDTH-1:0] v_out_r;

        assign m_sel = trans_q ? m_q[col_q][r] : m_q[r][col_q];
        // Both operands sign-extended to full product width before multiply.
        assign prod  = PW'(m_sel) * PW'(v_q[col_q]);

        // Arithmetic shift floors toward minus infinity.
        assign shifted = acc >>> FRAC_BITS;

        always_comb begin
            res        = shifted[WIDTH-1:0];
            res_ovf[r] = 1'b0;
            if (shifted > SAT_MAX) begin
                res_ovf[r] = 1'b1;
                if (SATURATE != 0) begin
                    res = RES_MAX;
                end
            end else if (shifted < SAT_MIN) begin
                res_ovf[r] = 1'b1;
                if (SATURATE != 0) begin
                    res = RES_MIN;
                end
            end
        end

        always_ff @(posedge clk_in or posedge rst_in) begin
            if (rst_in) begin
                acc     <= '0;
                v_out_r <= '0;
            end else begin
                if (load) begin
                    acc <= '0;
                end else if (accum) begin
                    acc <= acc + AW'(prod);
                end
                if (emit) begin
                    v_out_r <= res;
                end
            end
        end

        assign bus.v_out[r*WIDTH +: WIDTH] = v_out_r;
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.overflow = ovf_q;

endmodule

// File: doc/matrix_vector_seq_mac.md
MATRIX_VECTOR_SEQ_MAC -- requirements
Module: matrix_vector_seq_mac

Interface
- REQ-001: Parameter N, default 4, matrix dimension (rows = columns = vector length), N >= 2.
- REQ-002: Parameter WIDTH, default 32, signed element width in bits.
- REQ-003: Parameter FRAC_BITS, default 16, fractional bits of the fixed-point format; 0 = plain integer.
- REQ-004: Parameter SATURATE, default 1; 1 = clamp out-of-range results, 0 = wrap (keep low WIDTH bits).
- REQ-005: clk_in  input  1  single clock; all state changes on its rising edge.
- REQ-006: rst_in  input  1  reset, asynchronous, active-high.
- REQ-007: start  input  1  request a multiply; sampled only in IDLE.
- REQ-008: transpose  input  1  sampled with start; 1 = compute transpose(m1) x v1.
- REQ-009: m1  input  N*N*WIDTH  signed packed matrix, m1[row][col].
- REQ-010: v1  input  N*WIDTH  signed packed vector, v1[i].
- REQ-011: v_out  output  N*WIDTH  signed result vector, registered.
- REQ-012: busy  output  1  high while an operation is in progress.
- REQ-013: done  output  1  one-cycle pulse marking v_out valid.
- REQ-014: overflow  output  1  high with done if any element of that result was clamped or wrapped.

Function
- REQ-015: FSM states IDLE, ACCUM, OUTPUT; IDLE->ACCUM on start; ACCUM->OUTPUT after column N-1; OUTPUT->IDLE unconditionally.
- REQ-016: The edge sampling start in IDLE latches m1, v1 and transpose into internal registers, clears all N accumulators, sets column counter to 0 and busy to 1.
- REQ-017: Inputs m1, v1, transpose are don't-care after the start edge; changes while busy do not affect the result.
- REQ-018: Each ACCUM cycle adds, for every row r in parallel, m[r][c]*v[c] (or m[c][r]*v[c] when transpose) for the current column c, then increments c.
- REQ-019: Products are full 2*WIDTH signed; accumulators are 2*WIDTH+clog2(N) bits signed; no intermediate truncation.
- REQ-020: In OUTPUT each accumulator is arithmetic-shifted right by FRAC_BITS (truncation toward minus infinity), then reduced to WIDTH bits per SATURATE.
- REQ-021: SATURATE=1: values above 2^(WIDTH-1)-1 yield 2^(WIDTH-1)-1, values below -2^(WIDTH-1) yield -2^(WIDTH-1).
- REQ-022: Latency: with start sampled on edge 0, accumulation occurs on edges 1..N and v_out/done/overflow update on edge N+1 (5 edges for N=4).
- REQ-023: done is high for exactly one cycle after edge N+1; busy falls on the same edge.
- REQ-024: v_out and overflow hold their values until the next done; they never change outside that update edge.
- REQ-025: start while busy is ignored (not queued); start in the cycle done is high is accepted (back-to-back, period N+2 cycles).

Reset
- REQ-026: rst_in high asynchronously forces IDLE, busy=0, done=0, overflow=0, v_out=0, accumulators and counter to 0.
- REQ-027: Reset during ACCUM or OUTPUT aborts the operation; no done pulse is produced for it.
- REQ-028: First start is accepted on the first rising edge after rst_in deasserts.

Verification
- REQ-029: N=4, Q16.16, m1={{1,2,3,4},{5,6.5,7.75,8},{9,10,11.25,12},{13,14.125,15,16}}, v1={-3.5,6.5,7.75,12}, transpose=0 -> done on edge 5; v_out={0x0050C000,0x00B4D000,0x0108B000,0x01629000} (80.75,180.8125,264.6875,354.5625), overflow=0.
- REQ-030: Same m1, v1={1,0,0,0}, transpose=1 -> v_out={1,2,3,4} in Q16.16 (0x00010000,0x00020000,0x00030000,0x00040000).
- REQ-031: m1[0][0]=0x7FFF0000, v1[0]=0x00020000, all else 0 -> SATURATE=1: v_out[0]=0x7FFFFFFF, overflow=1; SATURATE=0: v_out[0]=0xFFFE0000, overflow=1.
- REQ-032: start held high continuously with constant inputs -> done pulses every 6 cycles (N=4), busy low for exactly one cycle between operations, identical v_out each time.
- REQ-033: rst_in pulsed on edge 2 of an operation -> busy=0 and v_out=0 immediately, no done; next start completes normally with correct result.
- REQ-034: m1/v1 changed to random values one cycle after start -> result equals product of the values present at the start edge.
